// File: rtl/mc6809_cpu.sv
// Reduced MC6809-compatible core: two-clock strobe bus (address phase, strobe phase), directed opcode subset.
// Define CPU_INDEXED_EN to add LDA/STA indexed on X (,X  ,X+  ,X++  ,-X  ,--X); otherwise A6/A7 are NOPs.
module mc6809_cpu #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFE
) (
    input  logic        cpu_clk,
    input  logic        cpu_reset,
    output logic        cpu_we_o,
    output logic        cpu_oe_o,
    output logic [15:0] cpu_addr_o,
    input  logic [7:0]  cpu_data_i,
    output logic [7:0]  cpu_data_o
);
    typedef enum logic [3:0] {RESET_HI, RESET_LO, FETCH, OPERAND_HI, OPERAND_LO,
                              EA_READ, RMW_WRITE, STORE_HI, STORE_LO, EXEC} state_t;
    localparam int CC_C = 0, CC_V = 1, CC_Z = 2, CC_N = 3;

    state_t      state, state_n;
    logic        ph, ph_n, second, second_n, adv, oe_n, we_n;
    logic [7:0]  op, op_n, a, a_n, b, b_n, tmp, tmp_n, cc, cc_n, dout_n;
    logic [15:0] pc, pc_n, x, x_n, ea, ea_n, addr_n, br;
`ifdef CPU_INDEXED_EN
    logic [1:0]  cnt, cnt_n;

    function automatic logic [1:0] idx_steps(input logic [7:0] pb);
        case (pb)
            8'h80, 8'h82: idx_steps = 2'd1;
            8'h81, 8'h83: idx_steps = 2'd2;
            default:      idx_steps = 2'd0;
        endcase
    endfunction

    function automatic state_t idx_access(input logic [7:0] o);
        idx_access = (o == 8'hA6) ? EA_READ : STORE_HI;
    endfunction
`endif

    function automatic logic [7:0] nz8(input logic [7:0] c, input logic [7:0] v);
        nz8 = c;
        nz8[CC_N] = v[7];
        nz8[CC_Z] = (v == 8'h00);
        nz8[CC_V] = 1'b0;
    endfunction

    function automatic logic [7:0] nz16(input logic [7:0] c, input logic [15:0] v);
        nz16 = c;
        nz16[CC_N] = v[15];
        nz16[CC_Z] = (v == 16'h0000);
        nz16[CC_V] = 1'b0;
    endfunction

    function automatic logic [7:0] inc_cc(input logic [7:0] c, input logic [7:0] v);
        inc_cc = nz8(c, v + 8'd1);
        inc_cc[CC_V] = (v == 8'h7F);
    endfunction

    function automatic logic [7:0] dec_cc(input logic [7:0] c, input logic [7:0] v);
        dec_cc = nz8(c, v - 8'd1);
        dec_cc[CC_V] = (v == 8'h80);
    endfunction

    always_comb begin
        state_n = state; ph_n = ph; second_n = second; op_n = op;
        a_n = a; b_n = b; x_n = x; pc_n = pc; ea_n = ea; tmp_n = tmp; cc_n = cc;
        addr_n = cpu_addr_o; dout_n = cpu_data_o; oe_n = 1'b0; we_n = 1'b0; adv = 1'b0;
`ifdef CPU_INDEXED_EN
        cnt_n = cnt;
`endif
        br = pc + 16'd1 + {{8{cpu_data_i[7]}}, cpu_data_i};
        if (state == EXEC || ph) begin
            adv = 1'b1;
        end else begin
            ph_n = 1'b1;
            oe_n = !(state inside {RMW_WRITE, STORE_HI, STORE_LO});
            we_n = !oe_n;
        end
        if (adv) begin
            ph_n = 1'b0;
            case (state)
                RESET_HI: begin tmp_n = cpu_data_i; state_n = RESET_LO; end
                RESET_LO: begin pc_n = {tmp, cpu_data_i}; state_n = FETCH; end
                FETCH: begin
                    op_n = cpu_data_i; pc_n = pc + 16'd1; second_n = 1'b0; state_n = FETCH;
                    case (cpu_data_i)
                        8'h86, 8'hC6, 8'h20, 8'h26, 8'h9E, 8'h97, 8'hD7, 8'h0F, 8'h0C, 8'h0A:
                            state_n = OPERAND_LO;
                        8'h8E, 8'hB6, 8'hF7, 8'hBF, 8'h7F, 8'h7C, 8'h7A:
                            state_n = OPERAND_HI;
                        8'h4C: begin a_n = a + 8'd1; cc_n = inc_cc(cc, a); end
                        8'h5C: begin b_n = b + 8'd1; cc_n = inc_cc(cc, b); end
`ifdef CPU_INDEXED_EN
                        8'hA6, 8'hA7: state_n = OPERAND_LO;
`endif
                        default: ;
                    endcase
                end
                OPERAND_HI: begin tmp_n = cpu_data_i; pc_n = pc + 16'd1; state_n = OPERAND_LO; end
                OPERAND_LO: begin
                    pc_n = pc + 16'd1; state_n = FETCH;
                    // direct page register is fixed at zero
                    ea_n = (op[7:4] inside {4'h0, 4'h9, 4'hD}) ? {8'h00, cpu_data_i} : {tmp, cpu_data_i};
                    case (op)
                        8'h86: begin a_n = cpu_data_i; cc_n = nz8(cc, cpu_data_i); end
                        8'hC6: begin b_n = cpu_data_i; cc_n = nz8(cc, cpu_data_i); end
                        8'h8E: begin x_n = {tmp, cpu_data_i}; cc_n = nz16(cc, {tmp, cpu_data_i}); end
                        8'h20: pc_n = br;
                        8'h26: if (!cc[CC_Z]) pc_n = br;
                        8'h9E, 8'hB6, 8'h0F, 8'h7F, 8'h0C, 8'h7C, 8'h0A, 8'h7A: state_n = EA_READ;
                        8'h97, 8'hD7, 8'hF7, 8'hBF: state_n = STORE_HI;
`ifdef CPU_INDEXED_EN
                        8'hA6, 8'hA7: begin
                            tmp_n = cpu_data_i; cnt_n = idx_steps(cpu_data_i); ea_n = x;
                            state_n = (cpu_data_i[1] && idx_steps(cpu_data_i) != 2'd0) ? EXEC : idx_access(op);
                        end
`endif
                        default: ;
                    endcase
                end
                EA_READ: begin
                    state_n = RMW_WRITE;
                    case (op)
                        8'hB6: begin a_n = cpu_data_i; cc_n = nz8(cc, cpu_data_i); state_n = FETCH; end
                        8'h9E: begin
                            if (!second) begin
                                tmp_n = cpu_data_i; ea_n = ea + 16'd1; second_n = 1'b1; state_n = EA_READ;
                            end else begin
                                x_n = {tmp, cpu_data_i}; cc_n = nz16(cc, {tmp, cpu_data_i}); state_n = FETCH;
                            end
                        end
                        8'h0F, 8'h7F: begin tmp_n = 8'h00; cc_n = (cc & 8'hF0) | 8'h04; end
                        8'h0C, 8'h7C: begin tmp_n = cpu_data_i + 8'd1; cc_n = inc_cc(cc, cpu_data_i); end
                        8'h0A, 8'h7A: begin tmp_n = cpu_data_i - 8'd1; cc_n = dec_cc(cc, cpu_data_i); end
`ifdef CPU_INDEXED_EN
                        8'hA6: begin
                            a_n = cpu_data_i; cc_n = nz8(cc, cpu_data_i);
                            state_n = (!tmp[1] && cnt != 2'd0) ? EXEC : FETCH;
                        end
`endif
                        default: state_n = FETCH;
                    endcase
                end
                RMW_WRITE: state_n = FETCH;
                STORE_HI: begin
                    if (op == 8'hBF) begin
                        ea_n = ea + 16'd1; cc_n = nz16(cc, x); state_n = STORE_LO;
                    end else begin
                        cc_n = nz8(cc, cpu_data_o); state_n = FETCH;
`ifdef CPU_INDEXED_EN
                        if (op == 8'hA7 && !tmp[1] && cnt != 2'd0) state_n = EXEC;
`endif
                    end
                end
                STORE_LO: state_n = FETCH;
                EXEC: begin
`ifdef CPU_INDEXED_EN
                    // one X adjust per clock; pre-decrement steps lead into the access
                    x_n = tmp[1] ? x - 16'd1 : x + 16'd1;
                    cnt_n = cnt - 2'd1; ea_n = x_n;
                    state_n = (cnt != 2'd1) ? EXEC : (tmp[1] ? idx_access(op) : FETCH);
`else
                    state_n = FETCH;
`endif
                end
                default: state_n = FETCH;
            endcase
            if (state_n != EXEC) begin
                case (state_n)
                    RESET_HI:                      addr_n = RESET_VECTOR;
                    RESET_LO:                      addr_n = RESET_VECTOR + 16'd1;
                    FETCH, OPERAND_HI, OPERAND_LO: addr_n = pc_n;
                    default:                       addr_n = ea_n;
                endcase
                case (state_n)
                    STORE_HI:  dout_n = (op_n == 8'hBF) ? x_n[15:8] : ((op_n == 8'hD7 || op_n == 8'hF7) ? b_n : a_n);
                    STORE_LO:  dout_n = x_n[7:0];
                    RMW_WRITE: dout_n = tmp_n;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state <= RESET_HI; ph <= 1'b0; second <= 1'b0; op <= 8'h00;
            a <= 8'h00; b <= 8'h00; x <= 16'h0000; pc <= 16'h0000; ea <= 16'h0000;
            tmp <= 8'h00; cc <= 8'h50;
            cpu_oe_o <= 1'b0; cpu_we_o <= 1'b0; cpu_addr_o <= RESET_VECTOR; cpu_data_o <= 8'h00;
`ifdef CPU_INDEXED_EN
            cnt <= 2'd0;
`endif
        end else begin
            state <= state_n; ph <= ph_n; second <= second_n; op <= op_n;
            a <= a_n; b <= b_n; x <= x_n; pc <= pc_n; ea <= ea_n;
            tmp <= tmp_n; cc <= cc_n;
            cpu_oe_o <= oe_n; cpu_we_o <= we_n; cpu_addr_o <= addr_n; cpu_data_o <= dout_n;
`ifdef CPU_INDEXED_EN
            cnt <= cnt_n;
`endif
        end
    end
endmodule

// File: tb/tb_mc6809_cpu.sv
// Directed program bench for mc6809_cpu: expected bus writes are queued up front and a
// forked monitor compares every write strobe against the queue head.
module tb_mc6809_cpu;
    logic        clk, cpu_reset, cpu_we_o, cpu_oe_o;
    logic [15:0] cpu_addr_o;
    logic [7:0]  rd, cpu_data_o;

    typedef struct packed {logic [15:0] addr; logic [7:0] data;} wr_t;
    wr_t         exp_q[$];
    logic [15:0] rlog[$];
    logic [7:0]  mem[65536];
    logic [7:0]  prog[66];
    int          n_vec, n_err;

    mc6809_cpu #(.RESET_VECTOR(16'hFFFE)) dut (
        .cpu_clk(clk), .cpu_reset(cpu_reset), .cpu_we_o(cpu_we_o), .cpu_oe_o(cpu_oe_o),
        .cpu_addr_o(cpu_addr_o), .cpu_data_i(rd), .cpu_data_o(cpu_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    task automatic push(input logic [15:0] ad, input logic [7:0] d);
        wr_t e;
        e.addr = ad; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic write_monitor();
        wr_t e;
        forever begin
            @(posedge cpu_we_o);
            n_vec++;
            if (cpu_oe_o) begin
                n_err++;
                $display("FAIL strobes: both strobes high at %h", cpu_addr_o);
            end
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got [%h]=%h, required no write", cpu_addr_o, cpu_data_o);
            end else begin
                e = exp_q.pop_front();
                if (e.addr !== cpu_addr_o || e.data !== cpu_data_o) begin
                    n_err++;
                    $display("FAIL write: got [%h]=%h, required [%h]=%h", cpu_addr_o, cpu_data_o, e.addr, e.data);
                end
            end
            mem[cpu_addr_o] = cpu_data_o;
        end
    endtask

    task automatic read_port();
        forever begin
            @(posedge cpu_oe_o);
            rd = mem[cpu_addr_o];
            rlog.push_back(cpu_addr_o);
        end
    endtask

    initial begin
        logic [15:0] l0, l1, l2;
        clk = 1'b0; cpu_reset = 1'b1; rd = 8'h00; n_vec = 0; n_err = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        prog = '{8'h8E, 8'h01, 8'h00, 8'hBF, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h0C, 8'h10, 8'h0A, 8'h10, 8'h26, 8'hF7, 8'hD7, 8'h21,
                 8'h86, 8'h7F, 8'h4C, 8'h97, 8'h22, 8'h8E, 8'h00, 8'h02, 8'hA7, 8'h80, 8'hA6, 8'h83, 8'h97, 8'h23, 8'hBF, 8'h00,
                 8'h24, 8'h7F, 8'h12, 8'h34, 8'hC6, 8'h7F, 8'hF7, 8'h12, 8'h34, 8'h5C, 8'h7C, 8'h12, 8'h34, 8'h20, 8'h0D, 8'h12,
                 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h20, 8'hFE, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h26, 8'hF7, 8'h97, 8'h40,
                 8'h20, 8'hFE};
        for (int i = 0; i < 66; i++) mem[16'h1000 + i] = prog[i];
        mem[16'hFFFE] = 8'h10; mem[16'hFFFF] = 8'h00; mem[16'h0001] = 8'h5A;
        fork
            write_monitor();
            read_port();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_oe", {15'd0, cpu_oe_o}, 16'h0000);
        chk("reset_we", {15'd0, cpu_we_o}, 16'h0000);
        chk("reset_addr", cpu_addr_o, 16'hFFFE);
        chk("reset_dout", {8'h00, cpu_data_o}, 16'h0000);

        // reset dropped into the middle of the vector low-byte read
        cpu_reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 cpu_reset = 1'b1;
        #1;
        chk("abort_oe", {15'd0, cpu_oe_o}, 16'h0000);
        chk("abort_addr", cpu_addr_o, 16'hFFFE);
        repeat (2) @(negedge clk);
        rlog.delete();

        push(16'h0102, 8'h01); push(16'h0103, 8'h00);
        push(16'h0010, 8'h00); push(16'h0010, 8'h01); push(16'h0010, 8'h00);
        push(16'h0021, 8'h00); push(16'h0022, 8'h80);
`ifdef CPU_INDEXED_EN
        push(16'h0002, 8'h80); push(16'h0023, 8'h5A); push(16'h0024, 8'h00); push(16'h0025, 8'h01);
`else
        push(16'h0023, 8'h80); push(16'h0024, 8'h00); push(16'h0025, 8'h02);
`endif
        push(16'h1234, 8'h00); push(16'h1234, 8'h7F); push(16'h1234, 8'h80);
        cpu_reset = 1'b0;

        repeat (1500) @(negedge clk);

        if (rlog.size() < 3) begin
            n_vec++; n_err++;
            $display("FAIL boot_reads: got %0d reads, required at least 3", rlog.size());
        end else begin
            chk("boot_read0", rlog[0], 16'hFFFE);
            chk("boot_read1", rlog[1], 16'hFFFF);
            chk("first_fetch", rlog[2], 16'h1000);
        end
        chk("pending_writes", 16'(exp_q.size()), 16'h0000);

        n_vec++;
        if (rlog.size() < 3) begin
            n_err++;
            $display("FAIL park_loop: got %0d reads, required loop at 1035", rlog.size());
        end else begin
            l0 = rlog[rlog.size()-1]; l1 = rlog[rlog.size()-2]; l2 = rlog[rlog.size()-3];
            if (!(l0 == l2 && ((l0 == 16'h1035 && l1 == 16'h1036) || (l0 == 16'h1036 && l1 == 16'h1035)))) begin
                n_err++;
                $display("FAIL park_loop: got reads %h %h %h, required alternating 1035/1036", l2, l1, l0);
            end
        end

        chk("final_cc", {8'h00, dut.cc}, 16'h005A);
`ifdef CPU_INDEXED_EN
        chk("final_x", dut.x, 16'h0001);
`else
        chk("final_x", dut.x, 16'h0002);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
